dmem_responder: RTL and testbench

Clocked data-memory responder serving the memory stage's load/store requests. Accepts level-held `rd`/`wr` requests with a size `mode`, performs a byte-addressed little-endian access after a programmable latency, and returns a one-cycle completion strobe (`rd_st` for loads, `wr_done` for stores). A full four-phase handshake lets the memory stage hold requests as levels without retriggering.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with programmable latency and a
// four-phase request handshake (IDLE -> WAIT -> DONE -> HOLD).
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  input  logic             wr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_st,
  output logic             wr_done,
  output logic             busy,
  output logic             err
);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = AW - 2;
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_mode;
  logic             r_is_rd;
  logic             r_is_wr;
  logic             r_bad;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rd_st;
  logic             r_wr_done;
  logic             r_busy;
  logic             r_err;

  logic [1:0]       w_span;
  logic [WIDTH:0]   w_last;
  logic             w_bad;
  logic [IW-1:0]    w_idx;
  logic [3:0]       w_lane_we;
  logic [31:0]      w_wrep;
  logic [31:0]      w_rword;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic [WIDTH-1:0] w_load;
  logic             w_finish;
  logic             w_commit;

  // Request legality is decided once, from the live inputs at the accept edge.
  always_comb begin
    case (mode)
      2'd0:    w_span = 2'd3;
      2'd1:    w_span = 2'd1;
      default: w_span = 2'd0;
    endcase
    w_last = {1'b0, add} + (WIDTH+1)'(w_span);
    w_bad  = (mode == 2'd3)
           || (mode == 2'd0 && add[1:0] != 2'b00)
           || (mode == 2'd1 && add[0])
           || (w_last >= (WIDTH+1)'(DEPTH_BYTES))
           || (rd && wr);
  end

  assign w_idx = r_addr[AW-1:2];

  always_comb begin
    case (r_mode)
      2'd0:    w_lane_we = 4'b1111;
      2'd1:    w_lane_we = r_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    w_lane_we = 4'b0001 << r_addr[1:0];
      default: w_lane_we = 4'b0000;
    endcase
    case (r_mode)
      2'd0:    w_wrep = r_wdata;
      2'd1:    w_wrep = {2{r_wdata[15:0]}};
      default: w_wrep = {4{r_wdata[7:0]}};
    endcase
  end

  assign w_finish = (r_state == S_WAIT) && (r_cnt == '0);
  // rst gating keeps a store from landing on an edge where reset is asserted.
  assign w_commit = w_finish && r_is_wr && !r_bad && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [WORDS];
      always_ff @(posedge clk) begin
        if (w_commit && w_lane_we[gi])
          r_mem[w_idx] <= w_wrep[8*gi +: 8];
      end
      assign w_rword[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  always_comb begin
    w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_byte = w_rword[8*r_addr[1:0] +: 8];
    case (r_mode)
      2'd0:    w_load = WIDTH'(w_rword);
      2'd1:    w_load = WIDTH'($signed(w_half));
      default: w_load = WIDTH'($signed(w_byte));
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mode    <= 2'd0;
      r_is_rd   <= 1'b0;
      r_is_wr   <= 1'b0;
      r_bad     <= 1'b0;
      r_rdata   <= '0;
      r_rd_st   <= 1'b0;
      r_wr_done <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd || wr) begin
            r_addr  <= add[AW-1:0];
            r_wdata <= wdata[31:0];
            r_mode  <= mode;
            r_is_rd <= rd;
            r_is_wr <= wr;
            r_bad   <= w_bad;
            r_cnt   <= CW'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_finish) begin
            r_rd_st   <= r_is_rd;
            r_wr_done <= r_is_wr;
            r_err     <= r_bad;
            if (r_bad)
              r_rdata <= '0;
            else if (r_is_rd)
              r_rdata <= w_load;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_rd_st   <= 1'b0;
          r_wr_done <= 1'b0;
          r_err     <= 1'b0;
          r_state   <= S_HOLD;
        end
        default: begin
          if (!(rd || wr)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign rdata   = r_rdata;
  assign rd_st   = r_rd_st;
  assign wr_done = r_wr_done;
  assign busy    = r_busy;
  assign err     = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1
// instance share the bus; sel chooses which one receives rd/wr.
module tb_dmem_responder;
  logic        clk;
  logic        rst;
  logic [31:0] add;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [1:0]  mode;
  logic        sel;

  logic [31:0] rdata2, rdata1;
  logic        rd_st2, rd_st1, wr_done2, wr_done1, busy2, busy1, err2, err1;
  logic [31:0] m_rdata;
  logic        m_rd_st, m_wr_done, m_busy, m_err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .add(add), .wdata(wdata),
    .rd(rd & ~sel), .wr(wr & ~sel), .mode(mode),
    .rdata(rdata2), .rd_st(rd_st2), .wr_done(wr_done2), .busy(busy2), .err(err2)
  );

  dmem_responder #(.WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .add(add), .wdata(wdata),
    .rd(rd & sel), .wr(wr & sel), .mode(mode),
    .rdata(rdata1), .rd_st(rd_st1), .wr_done(wr_done1), .busy(busy1), .err(err1)
  );

  assign m_rdata   = sel ? rdata1   : rdata2;
  assign m_rd_st   = sel ? rd_st1   : rd_st2;
  assign m_wr_done = sel ? wr_done1 : wr_done2;
  assign m_busy    = sel ? busy1    : busy2;
  assign m_err     = sel ? err1     : err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  // One full handshake: accept, wait for the strobe, check it, drop, return to IDLE.
  task automatic xact(input string tag, input logic r, input logic w, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    add = a; wdata = d; mode = m; rd = r; wr = w;
    tick();
    chk({tag, "/busy_acc"}, {31'd0, m_busy}, 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(m_rd_st || m_wr_done) && n < 8);
    chk({tag, "/latency"}, n, sel ? 32'd1 : 32'd2);
    chk({tag, "/rd_st"}, {31'd0, m_rd_st}, {31'd0, r});
    chk({tag, "/wr_done"}, {31'd0, m_wr_done}, {31'd0, w});
    chk({tag, "/err"}, {31'd0, m_err}, {31'd0, exp_err});
    if (r) chk({tag, "/rdata"}, m_rdata, exp_rdata);
    rd = 1'b0; wr = 1'b0;
    tick();
    chk({tag, "/strobes_off"}, {29'd0, m_rd_st, m_wr_done, m_err}, 32'd0);
    tick();
    chk({tag, "/idle"}, {31'd0, m_busy}, 32'd0);
    $display("[TB] %s done (%0d edges)", tag, n);
  endtask

  initial begin
    int pulses;
    logic busy_ok;
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; mode = 2'd0; add = '0; wdata = '0;
    tick(); tick();
    chk("reset/busy", {31'd0, m_busy}, 32'd0);
    chk("reset/strobes", {29'd0, m_rd_st, m_wr_done, m_err}, 32'd0);
    chk("reset/rdata", m_rdata, 32'd0);
    rst = 1'b0;
    tick();

    xact("st_w_10",  1'b0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_w_10",  1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("st_b_12",  1'b0, 1'b1, 2'd2, 32'h12, 32'hFFFFFF5A, 32'h0, 1'b0);
    xact("ld_w_10b", 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0);
    xact("ld_h_10",  1'b1, 1'b0, 2'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    xact("ld_b_12",  1'b1, 1'b0, 2'd2, 32'h12, 32'h0, 32'h0000005A, 1'b0);
    xact("ld_h_12",  1'b1, 1'b0, 2'd1, 32'h12, 32'h0, 32'hFFFFDE5A, 1'b0);
    xact("ld_b_13",  1'b1, 1'b0, 2'd2, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);

    xact("ld_w_11_mis", 1'b1, 1'b0, 2'd0, 32'h11, 32'h0, 32'h0, 1'b1);
    xact("st_w_3fc",    1'b0, 1'b1, 2'd0, 32'h3FC, 32'h11223344, 32'h0, 1'b0);
    xact("st_h_3ff_oor", 1'b0, 1'b1, 2'd1, 32'h3FF, 32'h0000ABCD, 32'h0, 1'b1);
    xact("ld_w_3fc",    1'b1, 1'b0, 2'd0, 32'h3FC, 32'h0, 32'h11223344, 1'b0);
    xact("ld_w_400_oor", 1'b1, 1'b0, 2'd0, 32'h400, 32'h0, 32'h0, 1'b1);
    xact("st_h_11_mis", 1'b0, 1'b1, 2'd1, 32'h11, 32'h00007777, 32'h0, 1'b1);
    xact("ld_mode3",    1'b1, 1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("ld_w_10c",    1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0);

    // Level-held load: exactly one strobe, busy throughout.
    add = 32'h10; mode = 2'd0; rd = 1'b1; pulses = 0; busy_ok = 1'b1;
    repeat (10) begin
      tick();
      if (m_rd_st) pulses++;
      if (m_busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("hold/pulses", pulses, 32'd1);
    chk("hold/busy", {31'd0, busy_ok}, 32'd1);
    rd = 1'b0;
    tick();
    chk("hold/idle", {31'd0, m_busy}, 32'd0);
    $display("[TB] hold done (%0d pulses)", pulses);

    // A store raised during WAIT of a load must be ignored.
    add = 32'h10; mode = 2'd0; rd = 1'b1;
    tick();
    wr = 1'b1; wdata = 32'h0;
    tick(); tick();
    chk("waitwr/rd_st", {31'd0, m_rd_st}, 32'd1);
    chk("waitwr/wr_done", {31'd0, m_wr_done}, 32'd0);
    chk("waitwr/err", {31'd0, m_err}, 32'd0);
    chk("waitwr/rdata", m_rdata, 32'hDE5ABEEF);
    rd = 1'b0; wr = 1'b0;
    tick(); tick();
    chk("waitwr/idle", {31'd0, m_busy}, 32'd0);
    $display("[TB] waitwr done");
    xact("ld_w_10d", 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0);

    // Reset during WAIT of a store discards it.
    xact("st_w_20", 1'b0, 1'b1, 2'd0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("ld_w_20", 1'b1, 1'b0, 2'd0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    add = 32'h20; wdata = 32'h12345678; mode = 2'd0; wr = 1'b1;
    tick();
    chk("rstmid/busy_acc", {31'd0, m_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid/busy", {31'd0, m_busy}, 32'd0);
    chk("rstmid/strobes", {29'd0, m_rd_st, m_wr_done, m_err}, 32'd0);
    chk("rstmid/rdata", m_rdata, 32'd0);
    wr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    $display("[TB] rstmid done");
    xact("ld_w_20b", 1'b1, 1'b0, 2'd0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // rd and wr together: both strobes with err, no write.
    xact("st_w_30",  1'b0, 1'b1, 2'd0, 32'h30, 32'h0BADCAFE, 32'h0, 1'b0);
    xact("rdwr_30",  1'b1, 1'b1, 2'd0, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("ld_w_30",  1'b1, 1'b0, 2'd0, 32'h30, 32'h0, 32'h0BADCAFE, 1'b0);

    // LATENCY=1 instance.
    sel = 1'b1;
    xact("l1_st_w_40", 1'b0, 1'b1, 2'd0, 32'h40, 32'h55AA1234, 32'h0, 1'b0);
    xact("l1_ld_w_40", 1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 32'h55AA1234, 1'b0);
    xact("l1_ld_b_41", 1'b1, 1'b0, 2'd2, 32'h41, 32'h0, 32'h00000012, 1'b0);
    xact("l1_ld_h_42", 1'b1, 1'b0, 2'd1, 32'h42, 32'h0, 32'h000055AA, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
